io_link_responder: RTL

Memory-mapped I/O responder on the far side of the CPU data memory's I/O handshake port. Serves CPU-driven requests on `y1`/`y2` and answers on `x1`/`x2`. Bridges them to two 4-deep, 28-bit valid/ready streams: a TX stream toward a peripheral and an RX stream from a peripheral. Both sides share the CPU clock; no synchronisers.

---
 rtl/io_link_responder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/io_link_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : io_link_responder                                               |
// | Purpose  : Four-phase CPU I/O responder bridging to TX/RX valid/ready FIFOs |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module io_link_responder #(
  parameter int DEPTH = 4,
  parameter int DW    = 28
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          y1,
  input  logic [DW+1:0] y2,
  output logic          x1,
  output logic [DW+1:0] x2,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready
);

  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [1:0] c_OP_STATUS = 2'b00;
  localparam logic [1:0] c_OP_PUSH   = 2'b01;
  localparam logic [1:0] c_OP_POP    = 2'b10;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  state_t r_state;

  logic [DW-1:0]   r_tx_mem [DEPTH];
  logic [c_AW-1:0] r_tx_wr, r_tx_rd;
  logic [c_CW-1:0] r_tx_count;
  logic [DW-1:0]   r_rx_mem [DEPTH];
  logic [c_AW-1:0] r_rx_wr, r_rx_rd;
  logic [c_CW-1:0] r_rx_count;

  logic [1:0]    w_op;
  logic          w_cmd;
  logic          w_tx_full, w_rx_empty;
  logic          w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic [DW-1:0] w_status;

  // Full/empty decisions use the counts registered at the start of the cycle.
  assign w_op       = y2[DW+1:DW];
  assign w_cmd      = (r_state == S_IDLE) && y1;
  assign w_tx_full  = (r_tx_count == c_CW'(DEPTH));
  assign w_rx_empty = (r_rx_count == '0);
  assign w_tx_push  = w_cmd && (w_op == c_OP_PUSH) && !w_tx_full;
  assign w_tx_pop   = out_valid && out_ready;
  assign w_rx_push  = in_valid && in_ready;
  assign w_rx_pop   = w_cmd && (w_op == c_OP_POP) && !w_rx_empty;

  assign out_valid = (r_tx_count != '0);
  assign out_data  = r_tx_mem[r_tx_rd];
  assign in_ready  = (r_rx_count != c_CW'(DEPTH));

  always_comb begin
    w_status      = '0;
    w_status[6:4] = 3'(r_tx_count);
    w_status[2:0] = 3'(r_rx_count);
  end

  always_ff @(posedge clk) begin
    if (w_tx_push) r_tx_mem[r_tx_wr] <= y2[DW-1:0];
    if (w_rx_push) r_rx_mem[r_rx_wr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_wr    <= '0;
      r_tx_rd    <= '0;
      r_tx_count <= '0;
      r_rx_wr    <= '0;
      r_rx_rd    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wr <= r_tx_wr + c_AW'(1);
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + c_AW'(1);
      if (w_rx_push) r_rx_wr <= r_rx_wr + c_AW'(1);
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + c_AW'(1);
      r_tx_count <= r_tx_count + c_CW'(w_tx_push) - c_CW'(w_tx_pop);
      r_rx_count <= r_rx_count + c_CW'(w_rx_push) - c_CW'(w_rx_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      x1      <= 1'b0;
      x2      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (y1) begin
            x1      <= 1'b1;
            r_state <= S_ACK;
            case (w_op)
              c_OP_STATUS: x2 <= {2'b00, w_status};
              c_OP_PUSH:   x2 <= {w_tx_full, 1'b0, {DW{1'b0}}};
              c_OP_POP:    x2 <= w_rx_empty ? '0 : {2'b01, r_rx_mem[r_rx_rd]};
              default:     x2 <= {2'b10, w_status};
            endcase
          end
        end
        default: begin
          // x2 deliberately holds across the ack fall until the next command.
          if (!y1) begin
            x1      <= 1'b0;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
